aha_tlx_training_initiator: RTL and testbench
=============================================

// Module: aha_tlx_training_initiator
// PURPOSE
//  SoC-side single-lane TLX training initiator: serialises a 32-bit training pattern MSB-first on the forward lane,
//  then checks that the far end returns the expected 32-bit pattern on the reverse lane. Counts
//  reverse-pattern matches and reports PASS/FAIL per lane. Replicated per lane by the TLX training controller.
// PARAMETERS
//  CNT_W    32    width of LENGTH, MIN_MATCH and MATCH_COUNT
//  TIMEOUT  1024  max cycles spent in LISTEN before FAIL (>=1)
// PORTS
//  CLK           in   1      clock
//  RESET         in   1      async reset, active-high
//  START         in   1      1-cycle pulse; begins a training run (accepted in IDLE, PASS, FAIL)
//  ABORT         in   1      cancels a run; returns to IDLE
//  FWD_SEQUENCE  in   32     pattern transmitted on forward lane
//  REV_SEQUENCE  in   32     pattern expected on reverse lane
//  LENGTH        in   CNT_W  number of forward bits to transmit
//  MIN_MATCH     in   CNT_W  reverse matches required for PASS
//  REV_DATA_IN   in   1      reverse-lane serial input
//  FWD_DATA_OUT  out  1      forward-lane serial output (registered)
//  BUSY          out  1      high in SEND or LISTEN
//  DONE          out  1      1-cycle pulse on entry to PASS or FAIL
//  PASS          out  1      level; high in PASS state
//  FAIL          out  1      level; high in FAIL state
//  MATCH_COUNT   out  CNT_W  reverse-pattern matches this run (saturating)
//  STATE         out  3      IDLE=0 SEND=1 LISTEN=2 PASS=3 FAIL=4
// BEHAVIOUR
//  Reset: STATE=IDLE; all outputs 0; shift reg, window, counters cleared. Takes effect immediately, incl. mid-run.
//  FWD_SEQUENCE/REV_SEQUENCE/LENGTH/MIN_MATCH sampled at START; later changes ignored until next START.
//  START (not ABORT) in IDLE/PASS/FAIL: load tx shift reg=FWD_SEQUENCE, clear bit_cnt, MATCH_COUNT, rx window,
//   rx_fill, timeout; PASS/FAIL drop; go SEND (or LISTEN directly if LENGTH==0). START in SEND/LISTEN ignored.
//  SEND: each cycle FWD_DATA_OUT<=tx[31]; tx rotates left by 1 (pattern repeats every 32 bits).
//   First bit on FWD_DATA_OUT the cycle after START; bit k (0-based) at START+1+k.
//   bit_cnt increments per bit; after bit LENGTH-1 is driven, next state LISTEN. Exactly LENGTH bits sent.
//  LISTEN/IDLE/PASS/FAIL: FWD_DATA_OUT=0.
//  RX (SEND and LISTEN only): window<={window[30:0],REV_DATA_IN}; rx_fill saturates at 32.
//   Match when rx_fill (after update) >=32 and updated window==REV_SEQUENCE; MATCH_COUNT+1, saturates at all-ones.
//   Overlapping matches count (a continuously repeated pattern matches once per 32 cycles).
//  LISTEN: timeout counts 0..TIMEOUT-1. If MATCH_COUNT (incl. this cycle's match) >= MIN_MATCH -> PASS;
//   else if timeout==TIMEOUT-1 -> FAIL. PASS has priority over timeout in the same cycle.
//   MIN_MATCH==0 -> PASS on first LISTEN cycle. Matches during SEND count but PASS only decided in LISTEN.
//  DONE asserts for exactly the first cycle in PASS or FAIL. PASS/FAIL/MATCH_COUNT hold until next START.
//  ABORT in SEND/LISTEN -> IDLE next cycle, no DONE, MATCH_COUNT holds. ABORT in PASS/FAIL -> IDLE, clears PASS/FAIL.
//   ABORT+START same cycle: ABORT wins.
//  BUSY = (STATE==SEND)|(STATE==LISTEN), registered with state.
// TESTING
//  1 LENGTH=64, FWD=5A6B7C8D, START@t0 -> FWD_DATA_OUT t1..t64 = 0101_1010_0110_1011_0111_1100_1000_1101 x2, then 0; LISTEN@t65.
//  2 Loop reverse driver sending REV=A5B4C3D2 continuously MSB-first, MIN_MATCH=4 -> PASS, DONE 1 cycle, MATCH_COUNT>=4.
//  3 REV_DATA_IN=0, LENGTH=32, MIN_MATCH=1 -> FAIL with DONE exactly TIMEOUT cycles after LISTEN entry; MATCH_COUNT=0.
//  4 ABORT at bit 10 of SEND -> STATE=IDLE, BUSY=0, FWD_DATA_OUT=0 next cycle; no DONE; START then restarts cleanly.
//  5 RESET asserted mid-LISTEN (async, off clock edge) -> all outputs 0 immediately; STATE=IDLE after release.
//  6 LENGTH=0, MIN_MATCH=0 -> no forward bits, PASS+DONE on cycle 2 after START; START during SEND ignored.

Source files
------------

// File: rtl/aha_tlx_training_initiator.sv
// aha_tlx_training_initiator
//   Single-lane TLX training initiator. Serialises a 32-bit training pattern
//   MSB-first on the forward lane. It then watches the reverse lane for the
//   expected 32-bit pattern and counts matches. When enough matches have been
//   seen it reports PASS; if LISTEN runs out of time it reports FAIL.
//
//   Parameters:
//     CNT_W        width of LENGTH, MIN_MATCH and MATCH_COUNT
//     TIMEOUT      maximum number of LISTEN cycles before FAIL (>=1)
//
//   Ports:
//     CLK, RESET   clock; asynchronous active-high reset
//     START        one-cycle pulse that begins a run (accepted in IDLE/PASS/FAIL)
//     ABORT        cancels a run or clears a result; takes priority over START
//     FWD_SEQUENCE pattern sent on the forward lane (sampled at START)
//     REV_SEQUENCE pattern expected on the reverse lane (sampled at START)
//     LENGTH       number of forward bits to send (sampled at START)
//     MIN_MATCH    reverse matches needed for PASS (sampled at START)
//     REV_DATA_IN  reverse-lane serial input
//     FWD_DATA_OUT forward-lane serial output (registered)
//     BUSY         high in SEND or LISTEN
//     DONE         one-cycle pulse on entry to PASS or FAIL
//     PASS, FAIL   result levels
//     MATCH_COUNT  saturating count of reverse-pattern matches in this run
//     STATE        IDLE=0 SEND=1 LISTEN=2 PASS=3 FAIL=4
module aha_tlx_training_initiator #(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic             ABORT,
  input  logic [31:0]      FWD_SEQUENCE,
  input  logic [31:0]      REV_SEQUENCE,
  input  logic [CNT_W-1:0] LENGTH,
  input  logic [CNT_W-1:0] MIN_MATCH,
  input  logic             REV_DATA_IN,
  output logic             FWD_DATA_OUT,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic             FAIL,
  output logic [CNT_W-1:0] MATCH_COUNT,
  output logic [2:0]       STATE
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SEND   = 3'd1,
    S_LISTEN = 3'd2,
    S_PASS   = 3'd3,
    S_FAIL   = 3'd4
  } state_t;

  localparam int unsigned     TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t             state_q, state_d;
  logic               fwd_q, fwd_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [31:0]        tx_q, tx_d;
  logic [31:0]        win_q, win_d;
  logic [5:0]         fill_q, fill_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TO_W-1:0]    to_q, to_d;
  logic [31:0]        rev_q, rev_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   min_q, min_d;

  logic [31:0]        win_upd;
  logic [5:0]         fill_upd;
  logic               hit;
  logic [CNT_W-1:0]   cnt_upd;

  always_comb begin
    // Reverse-lane window as it will be after this cycle's sample; the match
    // and the PASS decision both use the updated values.
    win_upd  = {win_q[30:0], REV_DATA_IN};
    fill_upd = (fill_q == 6'd32) ? fill_q : fill_q + 6'd1;
    hit      = (fill_upd == 6'd32) && (win_upd == rev_q);
    cnt_upd  = (hit && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;

    state_d   = state_q;
    fwd_d     = 1'b0;
    tx_d      = tx_q;
    win_d     = win_q;
    fill_d    = fill_q;
    bit_cnt_d = bit_cnt_q;
    cnt_d     = cnt_q;
    to_d      = to_q;
    rev_d     = rev_q;
    len_d     = len_q;
    min_d     = min_q;

    if (state_q == S_SEND || state_q == S_LISTEN) begin
      win_d  = win_upd;
      fill_d = fill_upd;
      cnt_d  = cnt_upd;
    end

    unique case (state_q)
      S_IDLE, S_PASS, S_FAIL: begin
        if (ABORT) begin
          state_d = S_IDLE;
        end else if (START) begin
          rev_d  = REV_SEQUENCE;
          len_d  = LENGTH;
          min_d  = MIN_MATCH;
          win_d  = '0;
          fill_d = '0;
          cnt_d  = '0;
          to_d   = '0;
          if (LENGTH == '0) begin
            state_d   = S_LISTEN;
            bit_cnt_d = '0;
          end else begin
            // Bit 0 is launched on the START edge so it appears the next cycle.
            state_d   = S_SEND;
            fwd_d     = FWD_SEQUENCE[31];
            tx_d      = {FWD_SEQUENCE[30:0], FWD_SEQUENCE[31]};
            bit_cnt_d = CNT_W'(1);
          end
        end
      end
      S_SEND: begin
        if (ABORT) begin
          state_d = S_IDLE;
        end else if (bit_cnt_q == len_q) begin
          state_d = S_LISTEN;
          to_d    = '0;
        end else begin
          fwd_d     = tx_q[31];
          tx_d      = {tx_q[30:0], tx_q[31]};
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      S_LISTEN: begin
        if (ABORT) begin
          state_d = S_IDLE;
        end else if (cnt_upd >= min_q) begin
          state_d = S_PASS;
        end else if (to_q == TO_LAST) begin
          state_d = S_FAIL;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_SEND) || (state_d == S_LISTEN);
    done_d = ((state_d == S_PASS) || (state_d == S_FAIL)) &&
             (state_q != S_PASS) && (state_q != S_FAIL);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      fwd_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      tx_q      <= '0;
      win_q     <= '0;
      fill_q    <= '0;
      bit_cnt_q <= '0;
      cnt_q     <= '0;
      to_q      <= '0;
      rev_q     <= '0;
      len_q     <= '0;
      min_q     <= '0;
    end else begin
      state_q   <= state_d;
      fwd_q     <= fwd_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      tx_q      <= tx_d;
      win_q     <= win_d;
      fill_q    <= fill_d;
      bit_cnt_q <= bit_cnt_d;
      cnt_q     <= cnt_d;
      to_q      <= to_d;
      rev_q     <= rev_d;
      len_q     <= len_d;
      min_q     <= min_d;
    end
  end

  assign FWD_DATA_OUT = fwd_q;
  assign BUSY         = busy_q;
  assign DONE         = done_q;
  assign PASS         = (state_q == S_PASS);
  assign FAIL         = (state_q == S_FAIL);
  assign MATCH_COUNT  = cnt_q;
  assign STATE        = state_q;

endmodule

// File: tb/tb_aha_tlx_training_initiator.sv
module tb_aha_tlx_training_initiator;

  localparam int CNT_W = 32;
  localparam int TMO   = 64;
  localparam int NMAX  = 300;

  logic             CLK = 1'b0;
  logic             RESET = 1'b1;
  logic             START = 1'b0;
  logic             ABORT = 1'b0;
  logic [31:0]      FWD_SEQUENCE = '0;
  logic [31:0]      REV_SEQUENCE = '0;
  logic [CNT_W-1:0] LENGTH = '0;
  logic [CNT_W-1:0] MIN_MATCH = '0;
  logic             REV_DATA_IN = 1'b0;
  logic             FWD_DATA_OUT, BUSY, DONE, PASS, FAIL;
  logic [CNT_W-1:0] MATCH_COUNT;
  logic [2:0]       STATE;

  int errors = 0;
  int checks = 0;

  aha_tlx_training_initiator #(.CNT_W(CNT_W), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .ABORT(ABORT),
    .FWD_SEQUENCE(FWD_SEQUENCE), .REV_SEQUENCE(REV_SEQUENCE),
    .LENGTH(LENGTH), .MIN_MATCH(MIN_MATCH), .REV_DATA_IN(REV_DATA_IN),
    .FWD_DATA_OUT(FWD_DATA_OUT), .BUSY(BUSY), .DONE(DONE), .PASS(PASS),
    .FAIL(FAIL), .MATCH_COUNT(MATCH_COUNT), .STATE(STATE)
  );

  always #5 CLK = ~CLK;

  // Compare all status outputs against expected values for the current cycle.
  task automatic check_all(input string tag, input int cyc, input logic [2:0] e_state,
                           input logic e_out, input logic e_done, input int e_cnt);
    logic e_busy, e_pass, e_fail;
    e_busy = (e_state == 3'd1) || (e_state == 3'd2);
    e_pass = (e_state == 3'd3);
    e_fail = (e_state == 3'd4);
    checks++;
    if (STATE !== e_state) begin errors++;
      $display("FAIL %s state cyc=%0d got=%0d exp=%0d", tag, cyc, STATE, e_state); end
    checks++;
    if (FWD_DATA_OUT !== e_out) begin errors++;
      $display("FAIL %s fwd_out cyc=%0d got=%b exp=%b", tag, cyc, FWD_DATA_OUT, e_out); end
    checks++;
    if (DONE !== e_done) begin errors++;
      $display("FAIL %s done cyc=%0d got=%b exp=%b", tag, cyc, DONE, e_done); end
    checks++;
    if ({BUSY, PASS, FAIL} !== {e_busy, e_pass, e_fail}) begin errors++;
      $display("FAIL %s busy/pass/fail cyc=%0d got=%b%b%b exp=%b%b%b", tag, cyc,
               BUSY, PASS, FAIL, e_busy, e_pass, e_fail); end
    checks++;
    if (MATCH_COUNT !== CNT_W'(e_cnt)) begin errors++;
      $display("FAIL %s match_count cyc=%0d got=%0d exp=%0d", tag, cyc, MATCH_COUNT, e_cnt); end
  endtask

  // One full training run checked cycle by cycle against a model derived
  // from the bit stream: a match at sample t means samples t-31..t spell REV.
  // mode 0: REV repeated with phase ph; 1: random bits; 2: all zeros.
  task automatic run(input string tag, input logic [31:0] fwd, input logic [31:0] rev,
                     input int len, input int mmin, input int mode, input int ph,
                     input int restart_at);
    logic rb [0:NMAX];
    int   cnt [0:NMAX];
    int   l_cyc, e_cyc, m, ok;
    logic passed;
    logic [2:0] es;
    logic eo;
    l_cyc = 1 + len;
    rb[0] = 1'b0;
    for (int t = 1; t <= NMAX; t++)
      rb[t] = (mode == 0) ? rev[31 - ((t + ph) % 32)] :
              (mode == 1) ? 1'($urandom) : 1'b0;
    cnt[0] = 0;
    for (int t = 1; t <= NMAX; t++) begin
      m = 0;
      if (t >= 32) begin
        ok = 1;
        for (int i = 0; i < 32; i++) if (rb[t-31+i] !== rev[31-i]) ok = 0;
        m = ok;
      end
      cnt[t] = cnt[t-1] + m;
    end
    e_cyc = -1;
    passed = 1'b0;
    for (int c = l_cyc; c <= l_cyc + TMO - 1 && e_cyc < 0; c++) begin
      if (cnt[c] >= mmin) begin e_cyc = c + 1; passed = 1'b1; end
      else if (c == l_cyc + TMO - 1) begin e_cyc = c + 1; passed = 1'b0; end
    end

    @(posedge CLK); #1;
    FWD_SEQUENCE = fwd; REV_SEQUENCE = rev;
    LENGTH = CNT_W'(len); MIN_MATCH = CNT_W'(mmin);
    START = 1'b1; ABORT = 1'b0; REV_DATA_IN = 1'b0;
    for (int t = 1; t <= e_cyc + 1; t++) begin
      @(posedge CLK); #1;
      START = (t == restart_at);
      // Configuration is captured at START; later changes must not matter.
      FWD_SEQUENCE = $urandom; REV_SEQUENCE = $urandom;
      LENGTH = CNT_W'($urandom_range(0, 5)); MIN_MATCH = CNT_W'($urandom_range(0, 5));
      es = (t < l_cyc) ? 3'd1 : (t < e_cyc) ? 3'd2 : (passed ? 3'd3 : 3'd4);
      eo = (t < l_cyc) ? fwd[31 - ((t - 1) % 32)] : 1'b0;
      check_all(tag, t, es, eo, (t == e_cyc), cnt[((t < e_cyc) ? t : e_cyc) - 1]);
      REV_DATA_IN = rb[t];
    end
    START = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge CLK);
    check_all("reset", 0, 3'd0, 1'b0, 1'b0, 0);
    RESET = 1'b0;
    @(posedge CLK); #1;
    check_all("reset_release", 1, 3'd0, 1'b0, 1'b0, 0);
  endtask

  task automatic test_pattern;
    run("pattern64", 32'h5A6B7C8D, 32'hA5B4C3D2, 64, 1, 2, 0, 0);
  endtask

  task automatic test_rev_loop;
    run("rev_loop", 32'h12345678, 32'hA5B4C3D2, 32, 4, 0, 0, 0);
    run("rev_loop_ph", 32'h0F0F1234, 32'hA5B4C3D2, 40, 2, 0, 17, 0);
  endtask

  task automatic test_timeout;
    run("timeout", 32'hDEADBEEF, 32'hA5B4C3D2, 32, 1, 2, 0, 0);
  endtask

  task automatic test_zero_len;
    run("zero_len", 32'hFFFFFFFF, 32'h13579BDF, 0, 0, 1, 0, 0);
    run("start_in_send", 32'hC3A50F96, 32'h2468ACE1, 20, 0, 1, 0, 5);
  endtask

  task automatic test_abort;
    logic [31:0] fwd;
    fwd = $urandom;
    @(posedge CLK); #1;
    FWD_SEQUENCE = fwd; REV_SEQUENCE = $urandom; LENGTH = 40; MIN_MATCH = 1;
    START = 1'b1;
    for (int t = 1; t <= 11; t++) begin
      @(posedge CLK); #1;
      START = 1'b0;
      REV_DATA_IN = 1'($urandom);
      check_all("abort_send", t, 3'd1, fwd[31 - (t - 1)], 1'b0, 0);
    end
    ABORT = 1'b1;
    START = 1'b1;
    for (int t = 12; t <= 15; t++) begin
      @(posedge CLK); #1;
      ABORT = 1'b0; START = 1'b0;
      check_all("abort_idle", t, 3'd0, 1'b0, 1'b0, 0);
    end
    run("after_abort", 32'h5A6B7C8D, 32'h00FF00FF, 8, 1, 0, 3, 0);
    // ABORT from a result state clears the result level.
    run("pre_abort_pass", 32'h1, 32'h2, 0, 0, 2, 0, 0);
    ABORT = 1'b1;
    @(posedge CLK); #1;
    ABORT = 1'b0;
    check_all("abort_pass", 0, 3'd0, 1'b0, 1'b0, 0);
  endtask

  task automatic test_async_reset;
    @(posedge CLK); #1;
    FWD_SEQUENCE = 32'hFFFFFFFF; REV_SEQUENCE = 32'h1; LENGTH = 4; MIN_MATCH = 5;
    REV_DATA_IN = 1'b0; START = 1'b1;
    for (int t = 1; t <= 10; t++) begin @(posedge CLK); #1; START = 1'b0; end
    checks++;
    if (STATE !== 3'd2) begin errors++;
      $display("FAIL async_pre state got=%0d exp=2", STATE); end
    #2 RESET = 1'b1;
    #1;
    check_all("async_reset", 0, 3'd0, 1'b0, 1'b0, 0);
    @(negedge CLK); RESET = 1'b0;
    @(posedge CLK); #1;
    check_all("async_release", 1, 3'd0, 1'b0, 1'b0, 0);
  endtask

  task automatic test_random;
    for (int n = 0; n < 12; n++)
      run("random", $urandom, $urandom, $urandom_range(0, 70), $urandom_range(0, 4),
          $urandom_range(0, 2), $urandom_range(0, 31), 0);
  endtask

  initial begin
    test_reset();
    test_pattern();
    test_rev_loop();
    test_timeout();
    test_zero_len();
    test_abort();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
